canvas_sequencer: RTL and testbench
===================================

# canvas_sequencer

Top-level controller for the 28×28 drawing canvas and the MNIST classifier input. It gates mouse drawing into the canvas editor and sweeps a canvas clear. It streams the 784 canvas pixels to the neural-network core over a valid/ready handshake, then waits for and holds the classification result. All three activities share the one canvas array, and this block serialises them so that no two overlap.

## Interface
Parameters:
- CANVAS_DIM, 28, canvas side length in pixels
- TIMEOUT_CYCLES, 1023, maximum WAIT duration before giving up
- AUTO_CLASSIFY, 1, when 1, releasing the draw button starts a classification automatically

Ports (reset Reset, asynchronous, active-high; clock frame_clk):
- frame_clk  in  1  clock
- Reset  in  1  asynchronous active-high reset
- draw_btn  in  1  mouse left button level, already synchronised
- clear_req  in  1  single-cycle clear request
- classify_req  in  1  single-cycle classify request
- edit_run  out  1  Run enable to the canvas editor
- canvas_clear  out  1  clear strobe to the canvas editor
- pix_x, pix_y  out  5 each  canvas read address
- pix_data  in  16  canvas[pix_x][pix_y], combinational
- nn_valid  out  1  stream beat valid
- nn_data  out  16  pixel value, pass-through of pix_data
- nn_last  out  1  final beat (index 783)
- nn_ready  in  1  NN core accepts beat
- nn_abort  out  1  one-cycle pulse: stream/result cancelled
- nn_done  in  1  NN result pulse
- nn_digit  in  4  NN result digit
- result_digit  out  4  held classification
- result_valid  out  1  result_digit is current for the canvas
- timeout_err  out  1  sticky: last classification timed out
- busy  out  1  state ≠ IDLE and state ≠ DRAW

## Operation
- States: IDLE, DRAW, CLEAR, STREAM, WAIT.
- IDLE:
  - Priority order: clear_req → CLEAR; else classify_req → STREAM; else draw_btn → DRAW.
  - Requests arriving in any other state are dropped, except as listed below.
- DRAW:
  - edit_run=1 while in DRAW; result_valid cleared on entry.
  - draw_btn=0 → STREAM if AUTO_CLASSIFY=1, else → IDLE.
  - clear_req → CLEAR.
- CLEAR:
  - canvas_clear=1 for exactly one cycle.
  - result_valid and timeout_err are cleared.
  - Next state is IDLE.
- STREAM:
  - Scan is row-major: pix_x runs 0..27 fastest, pix_y 0..27; index = pix_y*28+pix_x.
  - nn_valid=1 throughout; nn_data=pix_data.
  - Address advances only on nn_valid&&nn_ready.
  - nn_last=1 when index=783.
  - Accepted beat with nn_last → WAIT.
- WAIT:
  - nn_valid=0; a cycle counter runs.
  - nn_done → latch nn_digit into result_digit, set result_valid, go to IDLE.
  - Counter reaching TIMEOUT_CYCLES → set timeout_err, result_valid=0, pulse nn_abort, go to IDLE.
- clear_req in STREAM or WAIT: pulse nn_abort, drop nn_valid, go to CLEAR. It takes priority over nn_done in the same cycle.
- pix_x/pix_y reset to 0 on every STREAM entry.
- pix_x/pix_y do not wrap past 27/27 within one stream.

## Timing
- Reset values: state=IDLE; every output 0; result_digit=0.
- All outputs are registered, except nn_data (combinational from pix_data).
- Stream entry: nn_valid rises the cycle after the triggering classify_req or draw_btn fall.
- With nn_ready held high, STREAM lasts exactly 784 cycles. Each ready=0 cycle adds one cycle.
- While nn_valid=1 and nn_ready=0, pix_x, pix_y, nn_data and nn_last stay stable.
- nn_done is honoured on the first WAIT cycle. result_valid rises the cycle after nn_done.
- Timeout: nn_abort asserts TIMEOUT_CYCLES cycles after WAIT entry.
- Reset asserted mid-stream: immediate return to the reset values; no nn_abort pulse.
- nn_done outside WAIT is ignored.

## Structure
- canvas_pkg holds:
  - state enum seq_state_t
  - constants CANVAS_DIM=28, CANVAS_PIXELS=784, PIX_MAX=2047
  - the 5-bit coordinate typedef canvas_coord_t
- One sub-module, canvas_scan_counter:
  - Nested x/y counter with clear, advance and last outputs.
  - Reused by the VGA canvas readout.

## Test plan
- Reset, then classify_req with nn_ready=1 and the NN answering digit 7 at 5 cycles → 784 beats in order (0,0),(1,0)…(27,27), nn_last only on beat 783, result_digit=7, result_valid=1.
- nn_ready toggled 1-0-1 each cycle during STREAM → 1568 stream cycles; each beat's address and data are held across its stall cycle; no beat is duplicated or skipped.
- draw_btn held for 10 cycles, then released with AUTO_CLASSIFY=1 → edit_run high for 10 cycles and result_valid cleared; nn_valid rises the cycle after release.
- clear_req at stream beat 300 → nn_abort pulses once, nn_valid falls, canvas_clear pulses once the next cycle, then IDLE.
- No nn_done after the last beat → at TIMEOUT_CYCLES=1023, timeout_err=1, nn_abort pulses, result_valid=0, IDLE; a later clear_req clears timeout_err.
- clear_req and classify_req in the same IDLE cycle → CLEAR only; the classify request is dropped.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared types and constants for the canvas sequencer and the canvas raster counters.
package canvas_pkg;

  localparam int CANVAS_DIM    = 28;
  localparam int CANVAS_PIXELS = 784;
  localparam int PIX_MAX       = 2047;

  typedef logic [4:0] canvas_coord_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAW   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_WAIT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/canvas_scan_counter.sv
// Row-major x/y raster counter over a DIM x DIM canvas; x runs fastest and the
// count saturates on the final pixel instead of wrapping.
module canvas_scan_counter
  import canvas_pkg::*;
#(
  parameter int DIM = 28
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       advance,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic       last
);

  localparam canvas_coord_t COORD_MAX = canvas_coord_t'(DIM - 1);

  canvas_coord_t x_r;
  canvas_coord_t y_r;
  canvas_coord_t x_s;
  canvas_coord_t y_s;
  logic          last_r;
  logic          last_s;

  // Next coordinate: clear wins, advance holds once the final pixel is reached
  always_comb begin
    x_s = x_r;
    y_s = y_r;
    if (clear) begin
      x_s = 5'd0;
      y_s = 5'd0;
    end else if (advance && !last_r) begin
      if (x_r == COORD_MAX) begin
        x_s = 5'd0;
        y_s = y_r + 5'd1;
      end else begin
        x_s = x_r + 5'd1;
        y_s = y_r;
      end
    end else begin
      x_s = x_r;
      y_s = y_r;
    end
    last_s = (x_s == COORD_MAX) && (y_s == COORD_MAX);
  end

  // Coordinate and last-pixel registers
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_r    <= 5'd0;
      y_r    <= 5'd0;
      last_r <= 1'b0;
    end else begin
      x_r    <= x_s;
      y_r    <= y_s;
      last_r <= last_s;
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign last = last_r;

endmodule

// File: rtl/canvas_sequencer.sv
// Serialises drawing, clearing and NN classification on the shared 28x28 canvas:
// gates the editor, streams pixels to the NN core and holds its result.
module canvas_sequencer
  import canvas_pkg::*;
#(
  parameter int CANVAS_DIM     = 28,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter bit AUTO_CLASSIFY  = 1'b1
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        draw_btn,
  input  logic        clear_req,
  input  logic        classify_req,
  output logic        edit_run,
  output logic        canvas_clear,
  output logic [4:0]  pix_x,
  output logic [4:0]  pix_y,
  input  logic [15:0] pix_data,
  output logic        nn_valid,
  output logic [15:0] nn_data,
  output logic        nn_last,
  input  logic        nn_ready,
  output logic        nn_abort,
  input  logic        nn_done,
  input  logic [3:0]  nn_digit,
  output logic [3:0]  result_digit,
  output logic        result_valid,
  output logic        timeout_err,
  output logic        busy
);

  localparam int                WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t        state_r;
  seq_state_t        state_s;
  logic              edit_run_r,     edit_run_s;
  logic              canvas_clear_r, canvas_clear_s;
  logic              nn_valid_r,     nn_valid_s;
  logic              nn_abort_r,     nn_abort_s;
  logic [3:0]        result_digit_r, result_digit_s;
  logic              result_valid_r, result_valid_s;
  logic              timeout_err_r,  timeout_err_s;
  logic              busy_r,         busy_s;
  logic [WAIT_W-1:0] wait_cnt_r,     wait_cnt_s;
  logic              beat_accept_s;
  logic              scan_clear_s;
  logic              scan_advance_s;
  logic              scan_last_s;

  assign beat_accept_s = nn_valid_r && nn_ready;

  // Next state and next values of every registered output
  always_comb begin
    state_s        = state_r;
    canvas_clear_s = 1'b0;
    nn_abort_s     = 1'b0;
    result_digit_s = result_digit_r;
    result_valid_s = result_valid_r;
    timeout_err_s  = timeout_err_r;
    wait_cnt_s     = {WAIT_W{1'b0}};

    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_s = ST_CLEAR;
        end else if (classify_req) begin
          state_s = ST_STREAM;
        end else if (draw_btn) begin
          state_s        = ST_DRAW;
          result_valid_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (clear_req) begin
          state_s = ST_CLEAR;
        end else if (!draw_btn) begin
          state_s = AUTO_CLASSIFY ? ST_STREAM : ST_IDLE;
        end else begin
          state_s = ST_DRAW;
        end
      end
      ST_CLEAR: begin
        canvas_clear_s = 1'b1;
        result_valid_s = 1'b0;
        timeout_err_s  = 1'b0;
        state_s        = ST_IDLE;
      end
      ST_STREAM: begin
        if (clear_req) begin
          nn_abort_s = 1'b1;
          state_s    = ST_CLEAR;
        end else if (beat_accept_s && scan_last_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_WAIT: begin
        // A clear outranks a result arriving in the same cycle
        if (clear_req) begin
          nn_abort_s = 1'b1;
          state_s    = ST_CLEAR;
        end else if (nn_done) begin
          result_digit_s = nn_digit;
          result_valid_s = 1'b1;
          state_s        = ST_IDLE;
        end else if (wait_cnt_r == WAIT_LIMIT) begin
          timeout_err_s  = 1'b1;
          result_valid_s = 1'b0;
          nn_abort_s     = 1'b1;
          state_s        = ST_IDLE;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1'b1);
          state_s    = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    edit_run_s     = (state_s == ST_DRAW);
    nn_valid_s     = (state_s == ST_STREAM);
    busy_s         = (state_s != ST_IDLE) && (state_s != ST_DRAW);
    scan_clear_s   = (state_s == ST_STREAM) && (state_r != ST_STREAM);
    scan_advance_s = (state_r == ST_STREAM) && beat_accept_s;
  end

  // State and registered output bank
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_r        <= ST_IDLE;
      edit_run_r     <= 1'b0;
      canvas_clear_r <= 1'b0;
      nn_valid_r     <= 1'b0;
      nn_abort_r     <= 1'b0;
      result_digit_r <= 4'd0;
      result_valid_r <= 1'b0;
      timeout_err_r  <= 1'b0;
      busy_r         <= 1'b0;
      wait_cnt_r     <= {WAIT_W{1'b0}};
    end else begin
      state_r        <= state_s;
      edit_run_r     <= edit_run_s;
      canvas_clear_r <= canvas_clear_s;
      nn_valid_r     <= nn_valid_s;
      nn_abort_r     <= nn_abort_s;
      result_digit_r <= result_digit_s;
      result_valid_r <= result_valid_s;
      timeout_err_r  <= timeout_err_s;
      busy_r         <= busy_s;
      wait_cnt_r     <= wait_cnt_s;
    end
  end

  canvas_scan_counter #(
    .DIM (CANVAS_DIM)
  ) u_scan (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (scan_clear_s),
    .advance   (scan_advance_s),
    .x         (pix_x),
    .y         (pix_y),
    .last      (scan_last_s)
  );

  assign edit_run     = edit_run_r;
  assign canvas_clear = canvas_clear_r;
  assign nn_valid     = nn_valid_r;
  assign nn_data      = pix_data;
  assign nn_last      = scan_last_s;
  assign nn_abort     = nn_abort_r;
  assign result_digit = result_digit_r;
  assign result_valid = result_valid_r;
  assign timeout_err  = timeout_err_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_canvas_sequencer.sv
// Directed bench for canvas_sequencer: streaming, back-pressure, drawing, clear abort,
// timeout, request priority and reset behaviour against hand-derived expectations.
module tb_canvas_sequencer;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        draw_btn, clear_req, classify_req;
  logic        edit_run, canvas_clear;
  logic [4:0]  pix_x, pix_y;
  logic [15:0] pix_data;
  logic        nn_valid;
  logic [15:0] nn_data;
  logic        nn_last, nn_ready, nn_abort, nn_done;
  logic [3:0]  nn_digit, result_digit;
  logic        result_valid, timeout_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  // Canvas content model: each pixel encodes its own coordinates
  assign pix_data = {3'b101, pix_y, 3'b011, pix_x};

  canvas_sequencer #(
    .CANVAS_DIM     (28),
    .TIMEOUT_CYCLES (1023),
    .AUTO_CLASSIFY  (1'b1)
  ) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .draw_btn     (draw_btn),
    .clear_req    (clear_req),
    .classify_req (classify_req),
    .edit_run     (edit_run),
    .canvas_clear (canvas_clear),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .nn_valid     (nn_valid),
    .nn_data      (nn_data),
    .nn_last      (nn_last),
    .nn_ready     (nn_ready),
    .nn_abort     (nn_abort),
    .nn_done      (nn_done),
    .nn_digit     (nn_digit),
    .result_digit (result_digit),
    .result_valid (result_valid),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; draw_btn = 1'b0; clear_req = 1'b0; classify_req = 1'b0;
    nn_ready = 1'b0; nn_done = 1'b0; nn_digit = 4'd0;
    repeat (3) tick();
    checks++; if ({edit_run, canvas_clear, nn_valid, nn_last, nn_abort} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {edit_run, canvas_clear, nn_valid, nn_last, nn_abort}); end
    checks++; if ({pix_x, pix_y} !== 10'd0) begin errors++; $display("FAIL reset_addr: got x=%0d y=%0d expected 0 0", pix_x, pix_y); end
    checks++; if ({result_digit, result_valid, timeout_err, busy} !== 7'd0) begin errors++; $display("FAIL reset_result: got %b expected 0000000", {result_digit, result_valid, timeout_err, busy}); end
    Reset = 1'b0;
    tick();
    checks++; if ({busy, nn_valid, edit_run} !== 3'b000) begin errors++; $display("FAIL reset_idle: got %b expected 000", {busy, nn_valid, edit_run}); end
  endtask

  task automatic test_stream(input bit stall, input logic [3:0] digit, input int done_delay, input int exp_cycles);
    int idx, cyc, bad, lasts, first_bad;
    classify_req = 1'b1;
    tick();
    classify_req = 1'b0;
    checks++; if (nn_valid !== 1'b1) begin errors++; $display("FAIL stream_start: nn_valid got %b expected 1", nn_valid); end
    idx = 0; cyc = 0; bad = 0; lasts = 0; first_bad = -1;
    while (nn_valid === 1'b1 && cyc < 4000) begin
      cyc++;
      nn_ready = stall ? (cyc % 2 == 0) : 1'b1;
      if (pix_x !== 5'(idx % 28) || pix_y !== 5'(idx / 28) ||
          nn_data !== {3'b101, 5'(idx / 28), 3'b011, 5'(idx % 28)} || nn_last !== (idx == 783)) begin
        bad++;
        if (first_bad < 0) first_bad = idx;
      end
      if (nn_ready && nn_last) lasts++;
      if (nn_ready) idx++;
      tick();
    end
    nn_ready = 1'b0;
    checks++; if (cyc !== exp_cycles) begin errors++; $display("FAIL stream_cycles: got %0d expected %0d", cyc, exp_cycles); end
    checks++; if (idx !== 784) begin errors++; $display("FAIL stream_beats: got %0d expected 784", idx); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stream_beat_content: got %0d bad cycles (first beat %0d) expected 0", bad, first_bad); end
    checks++; if (lasts !== 1) begin errors++; $display("FAIL stream_last_count: got %0d expected 1", lasts); end
    checks++; if ({busy, nn_valid} !== 2'b10) begin errors++; $display("FAIL wait_entry: busy,nn_valid got %b expected 10", {busy, nn_valid}); end
    repeat (done_delay) tick();
    nn_done = 1'b1; nn_digit = digit;
    tick();
    nn_done = 1'b0; nn_digit = 4'd0;
    checks++; if (result_digit !== digit) begin errors++; $display("FAIL result_digit: got %0d expected %0d", result_digit, digit); end
    checks++; if ({result_valid, busy, nn_abort} !== 3'b100) begin errors++; $display("FAIL result_state: valid,busy,abort got %b expected 100", {result_valid, busy, nn_abort}); end
  endtask

  task automatic test_draw_auto();
    int runs;
    logic rv_first, busy_first, valid_draw;
    runs = 0; rv_first = 1'b1; busy_first = 1'b1; valid_draw = 1'b1;
    draw_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (edit_run === 1'b1) runs++;
      if (i == 0) begin rv_first = result_valid; busy_first = busy; end
      if (i == 9) valid_draw = nn_valid;
    end
    draw_btn = 1'b0;
    tick();
    if (edit_run === 1'b1) runs++;
    checks++; if (runs !== 10) begin errors++; $display("FAIL draw_edit_run_cycles: got %0d expected 10", runs); end
    checks++; if (rv_first !== 1'b0) begin errors++; $display("FAIL draw_clears_result: got %b expected 0", rv_first); end
    checks++; if ({busy_first, valid_draw} !== 2'b00) begin errors++; $display("FAIL draw_not_busy: busy,nn_valid got %b expected 00", {busy_first, valid_draw}); end
    checks++; if ({nn_valid, pix_x, pix_y} !== {1'b1, 10'd0}) begin errors++; $display("FAIL draw_auto_stream: valid=%b x=%0d y=%0d expected 1 0 0", nn_valid, pix_x, pix_y); end
  endtask

  task automatic test_clear_abort();
    nn_ready = 1'b1;
    repeat (300) tick();
    checks++; if ({pix_x, pix_y} !== {5'd20, 5'd10}) begin errors++; $display("FAIL beat300_addr: got x=%0d y=%0d expected 20 10", pix_x, pix_y); end
    clear_req = 1'b1; nn_ready = 1'b0;
    tick();
    clear_req = 1'b0;
    checks++; if ({nn_abort, nn_valid, canvas_clear} !== 3'b100) begin errors++; $display("FAIL abort_cycle: abort,valid,clear got %b expected 100", {nn_abort, nn_valid, canvas_clear}); end
    tick();
    checks++; if ({nn_abort, canvas_clear, busy} !== 3'b010) begin errors++; $display("FAIL clear_cycle: abort,clear,busy got %b expected 010", {nn_abort, canvas_clear, busy}); end
    tick();
    checks++; if ({nn_abort, canvas_clear, nn_valid, busy} !== 4'b0000) begin errors++; $display("FAIL after_clear: abort,clear,valid,busy got %b expected 0000", {nn_abort, canvas_clear, nn_valid, busy}); end
  endtask

  task automatic test_timeout();
    int n, early;
    classify_req = 1'b1;
    tick();
    classify_req = 1'b0; nn_ready = 1'b1; n = 0;
    while (nn_valid === 1'b1 && n < 2000) begin n++; tick(); end
    nn_ready = 1'b0;
    checks++; if (n !== 784) begin errors++; $display("FAIL timeout_stream_len: got %0d expected 784", n); end
    early = 0;
    repeat (1022) begin
      tick();
      if (nn_abort !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early: got %0d bad wait cycles expected 0", early); end
    checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL timeout_pre_valid: got %b expected 1", result_valid); end
    tick();
    checks++; if ({nn_abort, timeout_err, result_valid, busy} !== 4'b1100) begin errors++; $display("FAIL timeout_fire: abort,terr,valid,busy got %b expected 1100", {nn_abort, timeout_err, result_valid, busy}); end
    tick();
    checks++; if ({nn_abort, timeout_err} !== 2'b01) begin errors++; $display("FAIL timeout_sticky: abort,terr got %b expected 01", {nn_abort, timeout_err}); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    checks++; if ({canvas_clear, timeout_err} !== 2'b10) begin errors++; $display("FAIL timeout_cleared: clear,terr got %b expected 10", {canvas_clear, timeout_err}); end
  endtask

  task automatic test_priority();
    clear_req = 1'b1; classify_req = 1'b1;
    tick();
    clear_req = 1'b0; classify_req = 1'b0;
    checks++; if ({busy, nn_valid} !== 2'b10) begin errors++; $display("FAIL prio_clear_state: busy,valid got %b expected 10", {busy, nn_valid}); end
    tick();
    checks++; if ({canvas_clear, nn_valid} !== 2'b10) begin errors++; $display("FAIL prio_clear_pulse: clear,valid got %b expected 10", {canvas_clear, nn_valid}); end
    tick();
    checks++; if ({nn_valid, busy} !== 2'b00) begin errors++; $display("FAIL prio_classify_dropped: valid,busy got %b expected 00", {nn_valid, busy}); end
  endtask

  task automatic test_done_ignored_and_reset();
    nn_done = 1'b1; nn_digit = 4'd9;
    tick();
    nn_done = 1'b0;
    checks++; if ({result_digit, result_valid} !== {4'd3, 1'b0}) begin errors++; $display("FAIL done_in_idle: digit=%0d valid=%b expected 3 0", result_digit, result_valid); end
    classify_req = 1'b1;
    tick();
    classify_req = 1'b0; nn_ready = 1'b1; nn_done = 1'b1;
    tick();
    nn_done = 1'b0; nn_digit = 4'd0;
    checks++; if ({result_digit, result_valid, nn_valid} !== {4'd3, 1'b0, 1'b1}) begin errors++; $display("FAIL done_in_stream: digit=%0d valid=%b nn_valid=%b expected 3 0 1", result_digit, result_valid, nn_valid); end
    repeat (3) tick();
    #2 Reset = 1'b1;
    #1;
    checks++; if ({nn_valid, nn_abort, busy, pix_x, pix_y, result_digit} !== 17'd0) begin errors++; $display("FAIL async_reset: got %b expected all zero", {nn_valid, nn_abort, busy, pix_x, pix_y, result_digit}); end
    tick();
    checks++; if ({nn_abort, canvas_clear} !== 2'b00) begin errors++; $display("FAIL reset_no_abort: abort,clear got %b expected 00", {nn_abort, canvas_clear}); end
    nn_ready = 1'b0;
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream(1'b0, 4'd7, 4, 784);
    test_draw_auto();
    test_clear_abort();
    test_stream(1'b1, 4'd3, 0, 1568);
    test_timeout();
    test_priority();
    test_done_ignored_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
